// File: rtl/clock_div_pkg.sv
// -----------------------------------------------------------------------------
// clock_div_pkg
// Shared definitions for the programmable clock divider: controller state
// encoding, the smallest legal divide ratio and the default counter width.
// -----------------------------------------------------------------------------
package clock_div_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int MIN_DIV   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } state_e;

endpackage

// File: rtl/clock_div_ctrl_if.sv
// -----------------------------------------------------------------------------
// clock_div_ctrl_if
// Control/config bundle of the clock divider.
//   run        : level request to generate the divided clock
//   cfg_valid  : new divide ratio offered
//   cfg_div    : offered divide ratio
//   cfg_ready  : controller accepts a ratio this cycle
//   cfg_err    : one-cycle pulse after an illegal ratio was accepted
//   div_active : ratio currently generated
//   clk_out    : registered divided clock
//   tick       : last cycle of each output period
//   busy       : controller not idle
// master = requester side, slave = divider side.
// -----------------------------------------------------------------------------
interface clock_div_ctrl_if
    import clock_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             run;
    logic             cfg_valid;
    logic [WIDTH-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;
    logic [WIDTH-1:0] div_active;
    logic             clk_out;
    logic             tick;
    logic             busy;

    modport master (
        output run, cfg_valid, cfg_div,
        input  cfg_ready, cfg_err, div_active, clk_out, tick, busy
    );

    modport slave (
        input  run, cfg_valid, cfg_div,
        output cfg_ready, cfg_err, div_active, clk_out, tick, busy
    );
endinterface

// File: rtl/clock_div_core.sv
// -----------------------------------------------------------------------------
// clock_div_core
// Period counter, active-ratio register and divided-clock generation.
//   clk, rst       : clock, async active-high reset
//   i_enable       : counter will be running next cycle (next state != IDLE)
//   i_load         : load i_div as the active ratio at this edge
//   i_div          : ratio to load
//   o_div_active   : ratio currently in use
//   o_clk_out      : divided clock, straight from a flop
//   o_tick         : high on the last count of the period (wrap cycle)
// -----------------------------------------------------------------------------
module clock_div_core
    import clock_div_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RESET_DIV = 4
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_div_active,
    output logic             o_clk_out,
    output logic             o_tick
);
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_div;
    logic             r_clk_out;
    logic             r_act;      // counter was running this cycle

    logic             w_wrap;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_clk_nxt;

    assign w_wrap = r_act && (r_cnt == r_div - 1'b1);

    // clk_out is computed from the next count and the ratio that will be in
    // force next cycle, so the flop output lines up with cnt without any
    // decode after the register.
    always_comb begin
        w_div_nxt = i_load ? i_div : r_div;
        w_cnt_nxt = '0;
        if (i_enable && r_act && !w_wrap)
            w_cnt_nxt = r_cnt + 1'b1;
        w_clk_nxt = i_enable && (w_cnt_nxt >= (w_div_nxt >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_div     <= WIDTH'(RESET_DIV);
            r_clk_out <= 1'b0;
            r_act     <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_div     <= w_div_nxt;
            r_clk_out <= w_clk_nxt;
            r_act     <= i_enable;
        end
    end

    assign o_div_active = r_div;
    assign o_clk_out    = r_clk_out;
    assign o_tick       = w_wrap;
endmodule

// File: rtl/clock_div_ctrl.sv
// -----------------------------------------------------------------------------
// clock_div_ctrl
// Run/stop FSM and ratio handshake around clock_div_core. New ratios only take
// effect on a period boundary so no output period is shortened or stretched.
//   clk, rst : clock, async active-high reset
//   bus      : clock_div_ctrl_if slave (run, cfg_*, div_active, clk_out,
//              tick, busy)
// -----------------------------------------------------------------------------
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RESET_DIV = 4
)(
    input  logic             clk,
    input  logic             rst,
    clock_div_ctrl_if.slave  bus
);
    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pend_vld;
    logic             r_err;
    logic             r_live;     // first clock after reset seen

    logic             w_ready;
    logic             w_accept;
    logic             w_legal;
    logic             w_wrap;
    logic             w_load;
    logic [WIDTH-1:0] w_load_div;
    logic             w_pend_set;
    logic             w_pend_clr;
    logic             w_enable;

    // r_live keeps cfg_ready low through reset and until the first edge after
    // release.
    assign w_ready  = r_live && ((r_state == ST_IDLE) || (r_state == ST_RUN));
    assign w_accept = bus.cfg_valid && w_ready;
    assign w_legal  = bus.cfg_div >= WIDTH'(MIN_DIV);
    assign w_enable = (w_state_nxt != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_div  = bus.cfg_div;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_legal)
                    w_load = 1'b1;
                if (bus.run)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_accept && w_legal) begin
                    if (w_wrap) w_load     = 1'b1;
                    else        w_pend_set = 1'b1;
                end
                if (!bus.run)
                    w_state_nxt = w_wrap ? ST_IDLE : ST_STOP;
                else if (w_accept && w_legal && !w_wrap)
                    w_state_nxt = ST_PEND;
            end
            ST_PEND: begin
                if (w_wrap) begin
                    w_load      = 1'b1;
                    w_load_div  = r_pend_div;
                    w_pend_clr  = 1'b1;
                    w_state_nxt = bus.run ? ST_RUN : ST_IDLE;
                end else if (!bus.run) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // A ratio left pending from PEND still lands at this wrap;
                // resuming before the wrap goes back to PEND so it is kept.
                if (w_wrap) begin
                    w_load      = r_pend_vld;
                    w_load_div  = r_pend_div;
                    w_pend_clr  = 1'b1;
                    w_state_nxt = bus.run ? ST_RUN : ST_IDLE;
                end else if (bus.run) begin
                    w_state_nxt = r_pend_vld ? ST_PEND : ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pend_div <= '0;
            r_pend_vld <= 1'b0;
            r_err      <= 1'b0;
            r_live     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && !w_legal;
            r_live  <= 1'b1;
            if (w_pend_set) begin
                r_pend_div <= bus.cfg_div;
                r_pend_vld <= 1'b1;
            end else if (w_pend_clr) begin
                r_pend_div <= '0;
                r_pend_vld <= 1'b0;
            end
        end
    end

    clock_div_core #(
        .WIDTH     (WIDTH),
        .RESET_DIV (RESET_DIV)
    ) u_core (
        .clk          (clk),
        .rst          (rst),
        .i_enable     (w_enable),
        .i_load       (w_load),
        .i_div        (w_load_div),
        .o_div_active (bus.div_active),
        .o_clk_out    (bus.clk_out),
        .o_tick       (w_wrap)
    );

    assign bus.tick      = w_wrap;
    assign bus.cfg_ready = w_ready;
    assign bus.cfg_err   = r_err;
    assign bus.busy      = (r_state != ST_IDLE);
endmodule

// File: tb/tb_clock_div_ctrl.sv
module tb_clock_div_ctrl;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_div_ctrl_if #(.WIDTH(W)) bus();

    clock_div_ctrl #(.WIDTH(W), .RESET_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         run;
        logic         vld;
        logic [W-1:0] div;
        logic         clk_o;
        logic         tick;
        logic         busy;
        logic         rdy;
        logic         err;
        logic [W-1:0] dact;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic run, input logic vld, input int div,
                       input logic clk_o, input logic tick, input logic busy,
                       input logic rdy, input logic err, input int dact);
        vec_t v;
        v.run = run; v.vld = vld; v.div = W'(div);
        v.clk_o = clk_o; v.tick = tick; v.busy = busy;
        v.rdy = rdy; v.err = err; v.dact = W'(dact);
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic clk_o, input logic tick,
                         input logic busy, input logic rdy, input logic err,
                         input int dact);
        n_vec++;
        if (bus.clk_out !== clk_o || bus.tick !== tick || bus.busy !== busy ||
            bus.cfg_ready !== rdy || bus.cfg_err !== err || bus.div_active !== W'(dact)) begin
            n_bad++;
            $display("FAIL %s: got clk_out=%b tick=%b busy=%b ready=%b err=%b div=%0d, want clk_out=%b tick=%b busy=%b ready=%b err=%b div=%0d",
                     name, bus.clk_out, bus.tick, bus.busy, bus.cfg_ready, bus.cfg_err,
                     bus.div_active, clk_o, tick, busy, rdy, err, dact);
        end
    endtask

    // inputs change on the falling edge; outputs are sampled 1 ns after the
    // rising edge that consumed them
    task automatic drive(input logic run, input logic vld, input int div);
        @(negedge clk);
        bus.run       = run;
        bus.cfg_valid = vld;
        bus.cfg_div   = W'(div);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.run = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_div = '0;

        //   run vld div  clk tick busy rdy err dact
        add(0, 0, 0,    0, 0, 0, 1, 0, 4);   // idle after reset
        // reset ratio 4: 0,0,1,1 with tick on the 4th
        add(1, 0, 0,    0, 0, 1, 1, 0, 4);
        add(1, 0, 0,    0, 0, 1, 1, 0, 4);
        add(1, 0, 0,    1, 0, 1, 1, 0, 4);
        add(1, 0, 0,    1, 1, 1, 1, 0, 4);
        add(1, 0, 0,    0, 0, 1, 1, 0, 4);
        add(1, 0, 0,    0, 0, 1, 1, 0, 4);
        add(1, 0, 0,    1, 0, 1, 1, 0, 4);
        add(1, 0, 0,    1, 1, 1, 1, 0, 4);
        // illegal ratio 1: error pulse, waveform unchanged
        add(1, 1, 1,    0, 0, 1, 1, 1, 4);
        add(1, 0, 0,    0, 0, 1, 1, 0, 4);
        // ratio 6 mid-period: PEND, current period finishes, then 0,0,0,1,1,1
        add(1, 1, 6,    1, 0, 1, 0, 0, 4);
        add(1, 0, 0,    1, 1, 1, 0, 0, 4);
        add(1, 0, 0,    0, 0, 1, 1, 0, 6);
        add(1, 0, 0,    0, 0, 1, 1, 0, 6);
        add(1, 0, 0,    0, 0, 1, 1, 0, 6);
        add(1, 0, 0,    1, 0, 1, 1, 0, 6);
        add(1, 0, 0,    1, 0, 1, 1, 0, 6);
        add(1, 0, 0,    1, 1, 1, 1, 0, 6);
        // ratio 5 on the wrap cycle: next period 0,0,1,1,1
        add(1, 1, 5,    0, 0, 1, 1, 0, 5);
        add(1, 0, 0,    0, 0, 1, 1, 0, 5);
        add(1, 0, 0,    1, 0, 1, 1, 0, 5);
        add(1, 0, 0,    1, 0, 1, 1, 0, 5);
        add(1, 0, 0,    1, 1, 1, 1, 0, 5);
        // back to 4 on wrap, then stop at cnt=1
        add(1, 1, 4,    0, 0, 1, 1, 0, 4);
        add(1, 0, 0,    0, 0, 1, 1, 0, 4);
        add(0, 0, 0,    1, 0, 1, 0, 0, 4);
        add(0, 0, 0,    1, 1, 1, 0, 0, 4);
        add(0, 0, 0,    0, 0, 0, 1, 0, 4);
        add(0, 0, 0,    0, 0, 0, 1, 0, 4);
        // load in IDLE, illegal 0 in IDLE, run ratio 3 (0,1,1)
        add(0, 1, 3,    0, 0, 0, 1, 0, 3);
        add(0, 1, 0,    0, 0, 0, 1, 1, 3);
        add(1, 0, 0,    0, 0, 1, 1, 0, 3);
        add(1, 0, 0,    1, 0, 1, 1, 0, 3);
        add(1, 0, 0,    1, 1, 1, 1, 0, 3);
        add(1, 0, 0,    0, 0, 1, 1, 0, 3);
        // stop then resume before wrap (no restart), then stop on wrap
        add(0, 0, 0,    1, 0, 1, 0, 0, 3);
        add(1, 0, 0,    1, 1, 1, 1, 0, 3);
        add(0, 0, 0,    0, 0, 0, 1, 0, 3);

        // reset state
        #12;
        check("reset_hold", 0, 0, 0, 0, 0, 4);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("release_pre_edge", 0, 0, 0, 0, 0, 4);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].run, tbl[i].vld, int'(tbl[i].div));
            check($sformatf("vec%0d", i), tbl[i].clk_o, tbl[i].tick, tbl[i].busy,
                  tbl[i].rdy, tbl[i].err, int'(tbl[i].dact));
        end

        // async reset at cnt=3 while a ratio is pending
        drive(0, 1, 6);  check("rst_seq_load6", 0, 0, 0, 1, 0, 6);
        drive(1, 0, 0);  check("rst_seq_c0",    0, 0, 1, 1, 0, 6);
        drive(1, 0, 0);  check("rst_seq_c1",    0, 0, 1, 1, 0, 6);
        drive(1, 1, 9);  check("rst_seq_pend",  0, 0, 1, 0, 0, 6);
        drive(1, 0, 0);  check("rst_seq_c3",    1, 0, 1, 0, 0, 6);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", 0, 0, 0, 0, 0, 4);
        @(posedge clk);
        #1;
        check("rst_held", 0, 0, 0, 0, 0, 4);
        @(negedge clk);
        rst = 1'b0;
        bus.run = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_c0", 0, 0, 1, 1, 0, 4);
        // pending 9 must have been dropped: plain ratio-4 waveform
        drive(1, 0, 0);  check("post_rst_c1", 0, 0, 1, 1, 0, 4);
        drive(1, 0, 0);  check("post_rst_c2", 1, 0, 1, 1, 0, 4);
        drive(1, 0, 0);  check("post_rst_c3", 1, 1, 1, 1, 0, 4);
        drive(1, 0, 0);  check("post_rst_c0b", 0, 0, 1, 1, 0, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_div_ctrl.md
CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning bit width of the divide ratio and period counter.
REQ-002 SHALL have parameter RESET_DIV, default 4, meaning divide ratio loaded at reset (legal range 2..2^WIDTH-1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port run, input, 1 bit: level request to generate the divided clock.
REQ-006 SHALL have port cfg_valid, input, 1 bit: a new divide ratio is offered.
REQ-007 SHALL have port cfg_div, input, WIDTH bits: the offered divide ratio.
REQ-008 SHALL have port cfg_ready, output, 1 bit: the controller can accept a ratio this cycle.
REQ-009 SHALL have port cfg_err, output, 1 bit: one-cycle pulse when an accepted ratio was illegal.
REQ-010 SHALL have port div_active, output, WIDTH bits: the ratio currently being generated.
REQ-011 SHALL have port clk_out, output, 1 bit: the registered divided clock.
REQ-012 SHALL have port tick, output, 1 bit: high during the last cycle of each output period.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement the states IDLE, RUN, PEND and STOP.
REQ-015 SHALL hold the period counter cnt at 0 and clk_out at 0 in IDLE.
REQ-016 SHALL, in RUN/PEND/STOP, step cnt 0..div_active-1, wrap to 0, and drive clk_out 0 while cnt < div_active/2 (integer division) and 1 otherwise; clk_out is a flop with no combinational decode on the output.
REQ-017 SHALL assert tick when cnt == div_active-1 in RUN/PEND/STOP; this cycle is the "wrap cycle".
REQ-018 SHALL complete a handshake on a cycle with cfg_valid && cfg_ready; cfg_ready is 1 in IDLE and RUN and 0 in PEND, STOP and during reset.
REQ-019 SHALL treat an accepted cfg_div < 2 as illegal: pulse cfg_err the next cycle and discard the value, with no state change.
REQ-020 SHALL, for a legal ratio accepted in IDLE, load div_active the next cycle.
REQ-021 SHALL, for a legal ratio accepted in RUN on a non-wrap cycle, store it in a pending register and move to PEND.
REQ-022 SHALL, for a legal ratio accepted in RUN on a wrap cycle, load div_active at that wrap so that cnt=0 runs with the new ratio, and stay in RUN.
REQ-023 SHALL, in PEND on the wrap cycle, load the pending ratio into div_active, set cnt to 0 and return to RUN; no output period is ever shortened or stretched.
REQ-024 SHALL move IDLE->RUN on run=1, with cnt=0 on the next cycle.
REQ-025 SHALL move RUN or PEND to STOP on run=0, finish the current period, then go to IDLE after the wrap cycle; any pending ratio is still loaded at that wrap.
REQ-026 SHALL, on run=0 during the wrap cycle in RUN/PEND, go directly to IDLE.
REQ-027 SHALL return STOP->RUN on run=1 before the wrap, without restarting the period.
REQ-028 SHALL ensure cnt never exceeds div_active-1 and wraps mod div_active with no WIDTH overflow.

Reset
REQ-029 SHALL, on rst=1, immediately and asynchronously force: state IDLE, cnt 0, clk_out 0, tick 0, cfg_err 0, busy 0, cfg_ready 0, div_active RESET_DIV, and pending register cleared.
REQ-030 SHALL abort any in-flight period or pending ratio on reset assertion mid-operation; the first cfg_ready=1 is in the cycle after rst deasserts.

Structure
REQ-031 SHALL take the state enum, the MIN_DIV=2 constant and the default WIDTH from shared package clock_div_pkg.
REQ-032 SHALL place the counter and clk_out/tick generation in the sub-module clock_div_core (inputs: enable, div, load), with the FSM and handshake in clock_div_ctrl.

Verification
REQ-033 SHALL check reset then run=1 with RESET_DIV=4 -> clk_out 0,0,1,1 repeating, and tick on every 4th cycle.
REQ-034 SHALL check cfg_div=6 accepted mid-period in RUN -> PEND, cfg_ready=0, the current 4-cycle period completes, then clk_out 0,0,0,1,1,1.
REQ-035 SHALL check cfg_div=1 offered -> cfg_err pulses once, div_active remains 4, and the waveform is unchanged.
REQ-036 SHALL check run=0 at cnt=1 (div 4) -> busy stays 1 for 2 more cycles, then IDLE with clk_out=0.
REQ-037 SHALL check cfg_div=5 accepted on a wrap cycle -> the next period is 5 cycles (clk_out 0,0,1,1,1).
REQ-038 SHALL check rst asserted asynchronously at cnt=3 while in PEND -> outputs reach their reset values before the next clk edge, and div_active=RESET_DIV.
